// File: rtl/fu_wb_arbiter_pkg.sv
// rtl/fu_wb_arbiter_pkg.sv - shared types and constants for the execute-stage writeback arbiter
package fu_wb_arbiter_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     ex_valid;
  } wb_entry_t;

  // Channel indices used to hook functional units onto fu_* in the execute stage
  localparam int unsigned FU_ALU_BRANCH  = 0;
  localparam int unsigned FU_CSR         = 1;
  localparam int unsigned FU_MULT        = 2;
  localparam int unsigned FU_FPU         = 3;
  localparam int unsigned NR_FU_CHANNELS = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fu_wb_arbiter_fifo.sv
// rtl/fu_wb_arbiter_fifo.sv - per-channel result FIFO, any depth, synchronous flush
module wb_fifo
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  // Full is judged on registered count only, so a same-cycle pop never frees a slot early
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// rtl/fu_wb_arbiter.sv - round-robin arbiter from NrFus buffered result channels to NrWbPorts write ports
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrFus       = NR_FU_CHANNELS,
  parameter int unsigned NrWbPorts   = 2,
  parameter int unsigned Depth       = 2,
  parameter int unsigned DataWidth   = XLEN,
  parameter int unsigned TransIdBits = TRANS_ID_BITS,
  localparam int unsigned IdxW       = idx_width(NrFus)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NrFus-1:0]                 fu_valid_i,
  output logic [NrFus-1:0]                 fu_ready_o,
  input  logic [NrFus*DataWidth-1:0]       fu_result_i,
  input  logic [NrFus*TransIdBits-1:0]     fu_trans_id_i,
  input  logic [NrFus-1:0]                 fu_ex_valid_i,
  output logic [NrWbPorts-1:0]             wb_valid_o,
  output logic [NrWbPorts*DataWidth-1:0]   wb_result_o,
  output logic [NrWbPorts*TransIdBits-1:0] wb_trans_id_o,
  output logic [NrWbPorts-1:0]             wb_ex_valid_o,
  output logic [NrWbPorts*IdxW-1:0]        wb_fu_idx_o
);

  typedef struct packed {
    logic [DataWidth-1:0]   result;
    logic [TransIdBits-1:0] trans_id;
    logic                   ex_valid;
  } entry_t;

  entry_t           push_data [NrFus];
  entry_t           head      [NrFus];
  logic [NrFus-1:0] empty, full, pop;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  int unsigned      granted;

  for (genvar g = 0; g < NrFus; g++) begin : gen_ch
    assign push_data[g] = '{result:   fu_result_i[g*DataWidth +: DataWidth],
                            trans_id: fu_trans_id_i[g*TransIdBits +: TransIdBits],
                            ex_valid: fu_ex_valid_i[g]};
    assign fu_ready_o[g] = !full[g];

    wb_fifo #(
      .Depth   (Depth),
      .entry_t (entry_t)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (fu_valid_i[g]),
      .data_i  (push_data[g]),
      .pop_i   (pop[g]),
      .data_o  (head[g]),
      .empty_o (empty[g]),
      .full_o  (full[g])
    );
  end

  // Scan step s visits channel (rr_ptr + s) mod NrFus; the k-th hit drives port k
  always_comb begin
    wb_valid_o    = '0;
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    wb_ex_valid_o = '0;
    wb_fu_idx_o   = '0;
    pop           = '0;
    rr_ptr_d      = rr_ptr_q;
    granted       = 0;
    for (int unsigned s = 0; s < NrFus; s++) begin
      for (int unsigned c = 0; c < NrFus; c++) begin
        if (c == (32'(rr_ptr_q) + s) % NrFus && !empty[c] && granted < NrWbPorts) begin
          pop[c] = 1'b1;
          for (int unsigned k = 0; k < NrWbPorts; k++) begin
            if (granted == k) begin
              wb_valid_o[k]                               = 1'b1;
              wb_result_o[k*DataWidth +: DataWidth]       = head[c].result;
              wb_trans_id_o[k*TransIdBits +: TransIdBits] = head[c].trans_id;
              wb_ex_valid_o[k]                            = head[c].ex_valid;
              wb_fu_idx_o[k*IdxW +: IdxW]                 = IdxW'(c);
            end
          end
          rr_ptr_d = IdxW'((c + 1) % NrFus);
          granted  = granted + 1;
        end
      end
    end
    if (flush_i) rr_ptr_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb/tb_fu_wb_arbiter.sv - scoreboard bench for fu_wb_arbiter (default and 1x1x1 configurations)
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  localparam int NF = 4;
  localparam int NW = 2;
  localparam int DW = 64;
  localparam int TW = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst, flush;
  logic [NF-1:0]    fu_valid, fu_ready, fu_ex;
  logic [NF*DW-1:0] fu_result;
  logic [NF*TW-1:0] fu_tid;
  logic [NW-1:0]    wb_valid, wb_ex;
  logic [NW*DW-1:0] wb_result;
  logic [NW*TW-1:0] wb_tid;
  logic [NW*IW-1:0] wb_idx;

  logic          c_valid, c_ready, c_ex, c_wb_valid, c_wb_ex, c_wb_idx;
  logic [DW-1:0] c_result, c_wb_result;
  logic [TW-1:0] c_tid, c_wb_tid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] result;
    logic [TW-1:0] tid;
    logic          ex;
  } exp_t;
  exp_t exp_q [NF][$];
  logic [DW-1:0] exp_c [$];

  always #5 clk = ~clk;

  fu_wb_arbiter #(.NrFus(NF), .NrWbPorts(NW), .Depth(2), .DataWidth(DW), .TransIdBits(TW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(fu_ready), .fu_result_i(fu_result),
    .fu_trans_id_i(fu_tid), .fu_ex_valid_i(fu_ex),
    .wb_valid_o(wb_valid), .wb_result_o(wb_result), .wb_trans_id_o(wb_tid),
    .wb_ex_valid_o(wb_ex), .wb_fu_idx_o(wb_idx)
  );

  fu_wb_arbiter #(.NrFus(1), .NrWbPorts(1), .Depth(1), .DataWidth(DW), .TransIdBits(TW)) dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fu_valid_i(c_valid), .fu_ready_o(c_ready), .fu_result_i(c_result),
    .fu_trans_id_i(c_tid), .fu_ex_valid_i(c_ex),
    .wb_valid_o(c_wb_valid), .wb_result_o(c_wb_result), .wb_trans_id_o(c_wb_tid),
    .wb_ex_valid_o(c_wb_ex), .wb_fu_idx_o(c_wb_idx)
  );

  // Scoreboard: every valid port must match the head of its source channel's queue
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NW; p++) begin
        checks++;
        if (wb_valid[p]) begin
          int   c;
          exp_t e;
          c = int'(wb_idx[p*IW +: IW]);
          if (exp_q[c].size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected port=%0d fu=%0d got result=%h, required no entry", p, c, wb_result[p*DW +: DW]);
          end else begin
            e = exp_q[c].pop_front();
            if (wb_result[p*DW +: DW] !== e.result || wb_tid[p*TW +: TW] !== e.tid || wb_ex[p] !== e.ex) begin
              failures++;
              $display("FAIL sb_data port=%0d fu=%0d got %h/%0d/%b, required %h/%0d/%b", p, c,
                       wb_result[p*DW +: DW], wb_tid[p*TW +: TW], wb_ex[p], e.result, e.tid, e.ex);
            end
          end
        end else if (wb_result[p*DW +: DW] !== '0 || wb_tid[p*TW +: TW] !== '0 ||
                     wb_ex[p] !== 1'b0 || wb_idx[p*IW +: IW] !== '0) begin
          failures++;
          $display("FAIL silence port=%0d got %h/%0d/%b/%0d, required all zero", p,
                   wb_result[p*DW +: DW], wb_tid[p*TW +: TW], wb_ex[p], wb_idx[p*IW +: IW]);
        end
      end
      checks++;
      if (wb_valid === 2'b10) begin
        failures++;
        $display("FAIL port_order got wb_valid=%b, required port 0 used first", wb_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [DW-1:0] r, input logic [TW-1:0] t, input logic e, input bit keep);
    exp_t x;
    fu_valid[i] = 1'b1;
    fu_result[i*DW +: DW] = r;
    fu_tid[i*TW +: TW] = t;
    fu_ex[i] = e;
    if (keep) begin
      x.result = r;
      x.tid = t;
      x.ex = e;
      exp_q[i].push_back(x);
    end
  endtask

  task automatic clear_sb();
    for (int i = 0; i < NF; i++) exp_q[i].delete();
  endtask

  task automatic test_drained(input string name);
    int left;
    left = 0;
    for (int i = 0; i < NF; i++) left += exp_q[i].size();
    checks++;
    if (left != 0 || wb_valid !== '0) begin
      failures++;
      $display("FAIL %s_drained got %0d pending, wb_valid=%b, required 0 and 00", name, left, wb_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    fu_valid = '0; fu_result = '0; fu_tid = '0; fu_ex = '0;
    c_valid = 1'b0; c_result = '0; c_tid = '0; c_ex = 1'b0;
    #1;
    checks++;
    if (wb_valid !== '0 || wb_result !== '0 || wb_tid !== '0 || wb_ex !== '0 || wb_idx !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b idx=%h, required all zero", wb_valid, wb_idx);
    end
    checks++;
    if (fu_ready !== 4'hF || c_ready !== 1'b1 || c_wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b/%b, required 1111/1", fu_ready, c_ready);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    put(FU_MULT, 64'hDEAD, 3'd5, 1'b0, 1'b1);
    tick();
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b01 || wb_idx[IW-1:0] !== 2'd2 || wb_result[DW-1:0] !== 64'hDEAD || wb_tid[TW-1:0] !== 3'd5) begin
      failures++;
      $display("FAIL single_port0 got v=%b idx=%0d r=%h t=%0d, required 01/2/dead/5",
               wb_valid, wb_idx[IW-1:0], wb_result[DW-1:0], wb_tid[TW-1:0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b00 || fu_ready !== 4'hF) begin
      failures++;
      $display("FAIL single_empty got v=%b ready=%b, required 00/1111", wb_valid, fu_ready);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_contention();
    for (int i = 0; i < NF; i++) put(i, 64'h100 + 64'(i), 3'(i), 1'(i % 2), 1'b1);
    tick();
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b11 || wb_idx !== {2'd1, 2'd0}) begin
      failures++;
      $display("FAIL contention_c1 got v=%b idx=%h, required 11 with units 0,1", wb_valid, wb_idx);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b11 || wb_idx !== {2'd3, 2'd2}) begin
      failures++;
      $display("FAIL contention_c2 got v=%b idx=%h, required 11 with units 2,3", wb_valid, wb_idx);
    end
    tick();
    put(3, 64'h300, 3'd3, 1'b0, 1'b1);
    put(1, 64'h301, 3'd1, 1'b1, 1'b1);
    tick();
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (wb_idx !== {2'd3, 2'd1}) begin
      failures++;
      $display("FAIL contention_rr got idx=%h, required port0=1 port1=3 (rr_ptr 0)", wb_idx);
    end
    tick();
    @(negedge clk);
    test_drained("contention");
  endtask

  task automatic test_backpressure();
    tick();
    put(1, 64'h55, 3'd0, 1'b0, 1'b1);
    tick();
    fu_valid = '0;
    tick();
    put(0, 64'hA0, 3'd0, 1'b0, 1'b1);
    put(1, 64'hAAAA, 3'd1, 1'b0, 1'b1);
    put(2, 64'hB0, 3'd2, 1'b0, 1'b1);
    put(3, 64'hC0, 3'd3, 1'b0, 1'b1);
    tick();
    fu_valid[0] = 1'b0;
    put(1, 64'hBBBB, 3'd2, 1'b0, 1'b1);
    put(2, 64'hB1, 3'd4, 1'b1, 1'b1);
    put(3, 64'hC1, 3'd5, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (fu_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL bp_one_held got ready1=%b, required 1", fu_ready[1]);
    end
    tick();
    fu_valid[2] = 1'b0;
    fu_valid[3] = 1'b0;
    put(1, 64'hCCCC, 3'd3, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (fu_ready[1] !== 1'b0 || wb_idx !== {2'd1, 2'd0}) begin
      failures++;
      $display("FAIL bp_full got ready1=%b idx=%h, required 0 while popping units 0,1", fu_ready[1], wb_idx);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fu_ready[1] !== 1'b1 || wb_idx !== {2'd3, 2'd2}) begin
      failures++;
      $display("FAIL bp_reopen got ready1=%b idx=%h, required 1 with units 2,3 granted", fu_ready[1], wb_idx);
    end
    tick();
    fu_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    test_drained("backpressure");
  endtask

  task automatic test_flush();
    tick();
    put(0, 64'hF0, 3'd0, 1'b0, 1'b1);
    put(1, 64'hF1, 3'd1, 1'b0, 1'b1);
    put(2, 64'hF2, 3'd2, 1'b0, 1'b1);
    tick();
    fu_valid = '0;
    flush = 1'b1;
    put(3, 64'hBAD, 3'd7, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    fu_valid = '0;
    clear_sb();
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b00 || fu_ready !== 4'hF) begin
      failures++;
      $display("FAIL flush_clear got v=%b ready=%b, required 00/1111", wb_valid, fu_ready);
    end
    tick();
    @(negedge clk);
    test_drained("flush");
  endtask

  task automatic test_async_reset();
    tick();
    for (int i = 0; i < NF; i++) put(i, 64'h700 + 64'(i), 3'(i), 1'b0, 1'b1);
    tick();
    fu_valid = '0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wb_valid !== '0 || wb_result !== '0 || wb_tid !== '0 || wb_ex !== '0 || wb_idx !== '0 || fu_ready !== 4'hF) begin
      failures++;
      $display("FAIL async_reset got v=%b idx=%h ready=%b, required 00/0/1111", wb_valid, wb_idx, fu_ready);
    end
    clear_sb();
    tick();
    rst = 1'b0;
    put(3, 64'h803, 3'd3, 1'b0, 1'b1);
    put(1, 64'h801, 3'd1, 1'b0, 1'b1);
    tick();
    fu_valid = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b11 || wb_idx !== {2'd3, 2'd1}) begin
      failures++;
      $display("FAIL post_reset_rr got v=%b idx=%h, required 11 with port0=1 port1=3", wb_valid, wb_idx);
    end
    tick();
    @(negedge clk);
    test_drained("async_reset");
  endtask

  task automatic test_corner();
    logic [DW-1:0] v;
    tick();
    v = 64'd100;
    c_valid = 1'b1;
    c_result = v;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (c_ready !== 1'(i % 2 == 0) || c_wb_valid !== 1'(i % 2 == 1) || c_wb_idx !== 1'b0) begin
        failures++;
        $display("FAIL corner_cycle%0d got ready=%b valid=%b idx=%b, required %b/%b/0",
                 i, c_ready, c_wb_valid, c_wb_idx, 1'(i % 2 == 0), 1'(i % 2 == 1));
      end
      if (c_wb_valid === 1'b1) begin
        checks++;
        if (exp_c.size() == 0 || c_wb_result !== exp_c[0]) begin
          failures++;
          $display("FAIL corner_data cycle%0d got %h, required next accepted value", i, c_wb_result);
        end
        if (exp_c.size() != 0) void'(exp_c.pop_front());
      end
      if (i % 2 == 0) exp_c.push_back(v);
      tick();
      if (i % 2 == 0) begin
        v = v + 1;
        c_result = v;
      end
    end
    c_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
